// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-trial core.
// Holds the FSM state encoding and the printable-text acceptance rule.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    KSA_J,
    KSA_SWAP,
    PRGA_I,
    PRGA_J,
    PRGA_SWAP,
    PRGA_OUT,
    DONE_OK,
    DONE_FAIL
  } state_t;

  localparam logic [7:0] CHAR_LO   = 8'h61;
  localparam logic [7:0] CHAR_HI   = 8'h7A;
  localparam logic [7:0] CHAR_SP   = 8'h20;
  localparam int         KEY_BYTES = 3;

  // A decrypted byte is plausible plaintext only if it is 'a'..'z' or space.
  function automatic logic is_text_char(input logic [7:0] c);
    return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
  endfunction

endpackage

// File: rtl/rc4_s_array.sv
// 256x8 RC4 state array: two combinational read ports, two synchronous write ports.
// When both ports write the same address, port a wins; a swap then writes one value.
module rc4_s_array (
  input  logic       clk,
  input  logic [7:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [7:0] raddr_b,
  output logic [7:0] rdata_b,
  input  logic       we_a,
  input  logic [7:0] waddr_a,
  input  logic [7:0] wdata_a,
  input  logic       we_b,
  input  logic [7:0] waddr_b,
  input  logic [7:0] wdata_b
);

  logic [7:0] mem [256];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  // NOTE: no reset on the array; INIT rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (we_b) mem[waddr_b] <= wdata_b;
    if (we_a) mem[waddr_a] <= wdata_a;
  end

endmodule

// File: rtl/rc4_crack_core.sv
// RC4 trial decryption of one candidate key: INIT, KSA, PRGA over a ROM message,
// plaintext written to RAM, success/failure reported by the printable-text rule.
module rc4_crack_core
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reset_all,
  input  logic [23:0]   secret_key,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_q,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_data,
  output logic          ram_wren,
  output logic          busy,
  output logic          success,
  output logic          failure
);

  localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

  state_t        state, next_state;
  logic [23:0]   key;
  logic [7:0]    cnt, i, j, t;
  logic [AW-1:0] k;
  logic [1:0]    kidx;

  logic [7:0] s_raddr_a, s_rdata_a, s_rdata_b;
  logic       s_we_a, s_we_b;
  logic [7:0] s_waddr_a, s_wdata_a;
  logic [7:0] key_byte, d;
  logic       char_ok, abort;

  rc4_s_array u_s (
    .clk     (clk),
    .raddr_a (s_raddr_a),
    .rdata_a (s_rdata_a),
    .raddr_b (j),
    .rdata_b (s_rdata_b),
    .we_a    (s_we_a),
    .waddr_a (s_waddr_a),
    .wdata_a (s_wdata_a),
    .we_b    (s_we_b),
    .waddr_b (j),
    .wdata_b (s_rdata_a)
  );

  assign abort   = (state != IDLE) && !reset_all;
  // In PRGA_OUT port a fetches S[S[i]+S[j]] using the sum captured during the swap.
  assign s_raddr_a = (state == PRGA_OUT) ? t : i;
  assign d       = s_rdata_a ^ rom_q;
  assign char_ok = is_text_char(d);

  always_comb begin
    case (kidx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    s_we_a     = 1'b0;
    s_we_b     = 1'b0;
    s_waddr_a  = i;
    s_wdata_a  = s_rdata_b;
    case (state)
      IDLE:      if (reset_all) next_state = INIT;
      INIT: begin
        s_we_a    = 1'b1;
        s_waddr_a = cnt;
        s_wdata_a = cnt;
        if (cnt == 8'hFF) next_state = KSA_J;
      end
      KSA_J:     next_state = KSA_SWAP;
      KSA_SWAP: begin
        s_we_a     = 1'b1;
        s_we_b     = 1'b1;
        next_state = (i == 8'hFF) ? PRGA_I : KSA_J;
      end
      PRGA_I:    next_state = PRGA_J;
      PRGA_J:    next_state = PRGA_SWAP;
      PRGA_SWAP: begin
        s_we_a     = 1'b1;
        s_we_b     = 1'b1;
        next_state = PRGA_OUT;
      end
      PRGA_OUT: begin
        if (!char_ok)         next_state = DONE_FAIL;
        else if (k == LAST_K) next_state = DONE_OK;
        else                  next_state = PRGA_I;
      end
      default: ;
    endcase
    if (abort || reset) begin
      s_we_a = 1'b0;
      s_we_b = 1'b0;
    end
    if (abort) next_state = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      key      <= '0;
      cnt      <= '0;
      i        <= '0;
      j        <= '0;
      t        <= '0;
      k        <= '0;
      kidx     <= '0;
      rom_addr <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
    end else begin
      state    <= next_state;
      ram_wren <= 1'b0;
      if (reset_all) begin
        case (state)
          IDLE: begin
            key <= secret_key;
            cnt <= '0;
          end
          INIT: begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'hFF) begin
              i    <= '0;
              j    <= '0;
              kidx <= '0;
            end
          end
          KSA_J: j <= j + s_rdata_a + key_byte;
          KSA_SWAP: begin
            if (i == 8'hFF) begin
              i <= '0;
              j <= '0;
              k <= '0;
            end else begin
              i    <= i + 8'd1;
              kidx <= (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
            end
          end
          PRGA_I: begin
            i        <= i + 8'd1;
            rom_addr <= k;
          end
          PRGA_J:    j <= j + s_rdata_a;
          PRGA_SWAP: t <= s_rdata_a + s_rdata_b;
          PRGA_OUT: begin
            ram_wren <= 1'b1;
            ram_addr <= k;
            ram_data <= d;
            if (char_ok && (k != LAST_K)) k <= k + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign busy    = (state != IDLE) && (state != DONE_OK) && (state != DONE_FAIL);
  assign success = (state == DONE_OK);
  assign failure = (state == DONE_FAIL);

endmodule

// File: tb/tb_rc4_crack_core.sv
// Self-checking bench for rc4_crack_core: a plain RC4 reference builds the ROM,
// and edge-exact timing, written plaintext and handshake levels are compared.
module tb_rc4_crack_core;

  localparam int MSG_LEN = 32;
  localparam int AW      = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          reset_all;
  logic [23:0]   secret_key;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_q;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_wren;
  logic          busy, success, failure;

  int tests = 0;
  int fails = 0;

  logic [7:0] plain   [MSG_LEN];
  logic [7:0] rom_mem [MSG_LEN];
  int         wr_addr [$];
  int         wr_data [$];

  rc4_crack_core #(.MSG_LEN(MSG_LEN), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reset_all  (reset_all),
    .secret_key (secret_key),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .success    (success),
    .failure    (failure)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle registered read latency.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // RAM write log, sampled mid-cycle so each one-cycle strobe is seen once.
  always @(negedge clk) begin
    if (ram_wren) begin
      wr_addr.push_back(int'(ram_addr));
      wr_data.push_back(int'(ram_data));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Textbook RC4 (KSA + PRGA) producing the ROM image for the current plaintext.
  task automatic load_rom(input logic [23:0] key);
    int s [256];
    int kb [3];
    int a, b, tmp;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    b = 0;
    for (int n = 0; n < 256; n++) begin
      b = (b + s[n] + kb[n % 3]) % 256;
      tmp = s[n]; s[n] = s[b]; s[b] = tmp;
    end
    a = 0;
    b = 0;
    for (int n = 0; n < MSG_LEN; n++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
      rom_mem[n] = 8'(s[(s[a] + s[b]) % 256]) ^ plain[n];
    end
  endtask

  function automatic int first_bad();
    for (int n = 0; n < MSG_LEN; n++)
      if (!((plain[n] >= "a" && plain[n] <= "z") || plain[n] == " ")) return n;
    return -1;
  endfunction

  task automatic set_text(input string s);
    for (int n = 0; n < MSG_LEN; n++) plain[n] = s[n];
  endtask

  task automatic rand_text(input int bad_idx);
    int r;
    for (int n = 0; n < MSG_LEN; n++) begin
      r = int'($urandom_range(0, 26));
      plain[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
    end
    if (bad_idx >= 0) begin
      do plain[bad_idx] = 8'($urandom_range(0, 255));
      while ((plain[bad_idx] >= "a" && plain[bad_idx] <= "z") || plain[bad_idx] == " ");
    end
  endtask

  // Starts a run from IDLE (call mid-cycle), checks completion edge, writes and handshake.
  task automatic run_check(input logic [23:0] key, input string tag, input int hold);
    int f, n, e;
    load_rom(key);
    f = first_bad();
    n = (f < 0) ? MSG_LEN : f + 1;
    e = 768 + 4 * n;
    wr_addr.delete();
    wr_data.delete();
    secret_key = key;
    reset_all  = 1'b1;
    step(1);
    check({tag, "_busy_init"}, busy, 1);
    secret_key = ~key;
    step(e - 1);
    check({tag, "_busy_pre"}, busy, 1);
    check({tag, "_done_pre"}, {success, failure}, 2'b00);
    step(1);
    check({tag, "_success"}, success, (f < 0));
    check({tag, "_failure"}, failure, (f >= 0));
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_wr_count"}, wr_addr.size(), n);
    for (int q = 0; q < n && q < wr_addr.size(); q++) begin
      check($sformatf("%s_wr_addr%0d", tag, q), wr_addr[q], q);
      check($sformatf("%s_wr_data%0d", tag, q), wr_data[q], int'(plain[q]));
    end
    if (hold > 0) begin
      step(hold);
      check({tag, "_hold"}, {success, failure}, {(f < 0), (f >= 0)});
    end
    reset_all = 1'b0;
    step(1);
    check({tag, "_clear"}, {busy, success, failure, ram_wren}, 4'b0000);
    check({tag, "_wr_after"}, wr_addr.size(), n);
  endtask

  initial begin
    logic [23:0] rkey;
    reset      = 1'b1;
    reset_all  = 1'b0;
    secret_key = '0;
    step(3);
    check("rst_outputs", {busy, success, failure, ram_wren}, 4'b0000);
    check("rst_addrs", {rom_addr, ram_addr, ram_data}, '0);
    reset = 1'b0;
    step(1);

    // Golden message, then handshake hold.
    set_text("the quick brown fox jumps over t");
    run_check(24'h000249, "golden", 50);

    // Failure at the first byte.
    set_text("the quick brown fox jumps over t");
    plain[0] = 8'h41;
    run_check(24'h000249, "fail0", 0);

    // Failure at the last byte.
    set_text("the quick brown fox jumps over t");
    plain[MSG_LEN-1] = 8'h7B;
    run_check(24'h000249, "faillast", 0);

    // Abort mid-KSA, then a fresh run with a new key.
    set_text("the quick brown fox jumps over t");
    load_rom(24'h000249);
    wr_addr.delete();
    wr_data.delete();
    secret_key = 24'h000249;
    reset_all  = 1'b1;
    step(400);
    reset_all = 1'b0;
    step(1);
    check("abort_outputs", {busy, success, failure, ram_wren}, 4'b0000);
    check("abort_writes", wr_addr.size(), 0);
    step(1);
    rand_text(-1);
    run_check(24'(($urandom)), "post_abort", 0);

    // Synchronous reset during PRGA byte 10, reset_all held high.
    rand_text(-1);
    rkey = 24'($urandom);
    load_rom(rkey);
    secret_key = rkey;
    reset_all  = 1'b1;
    step(810);
    reset = 1'b1;
    step(1);
    check("sreset_outputs", {busy, success, failure, ram_wren}, 4'b0000);
    check("sreset_addrs", {rom_addr, ram_addr, ram_data}, '0);
    reset = 1'b0;
    run_check(rkey, "post_reset", 0);

    // Key wrap extremes and random keys.
    rand_text(-1);
    run_check(24'h000000, "key_zero", 0);
    rand_text(-1);
    run_check(24'hFFFFFF, "key_ones", 0);
    for (int r = 0; r < 3; r++) begin
      rand_text(-1);
      run_check(24'($urandom), $sformatf("rand%0d", r), 0);
    end
    rand_text(int'($urandom_range(1, MSG_LEN - 2)));
    run_check(24'($urandom), "rand_fail", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
